// File: rtl/demux_router.sv
// demux_router: steers each accepted word into one of two small FIFOs
// selected by `select`, and presents each FIFO head on its own output
// with a valid/ready handshake. Every output is driven from a register
// except in_ready. in_ready has to follow `select` in the same cycle.
// Per-output delivery counters wrap silently at 16 bits.
module demux_router #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     select,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         output0,
  output logic [WIDTH-1:0]         output1,
  output logic                     out_valid0,
  output logic                     out_valid1,
  input  logic                     out_ready0,
  input  logic                     out_ready1,
  output logic [$clog2(DEPTH):0]   level0,
  output logic [$clog2(DEPTH):0]   level1,
  output logic [15:0]              count0,
  output logic [15:0]              count1
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Queue storage and per-queue state, indexed by queue number.
  logic [WIDTH-1:0] r_mem [2][DEPTH];
  logic [AW-1:0]    r_rd  [2];
  logic [AW-1:0]    r_wr  [2];
  logic [LW-1:0]    r_lvl [2];
  logic [WIDTH-1:0] r_out [2];
  logic             r_vld [2];
  logic [15:0]      r_cnt [2];

  logic             w_full   [2];
  logic             w_acc;
  logic             w_ordy   [2];
  logic             w_push   [2];
  logic             w_pop    [2];
  logic [AW-1:0]    w_rd_nxt [2];
  logic [LW-1:0]    w_lvl_nxt[2];
  logic [WIDTH-1:0] w_head_nxt[2];

  assign w_ordy[0] = out_ready0;
  assign w_ordy[1] = out_ready1;

  // Ready depends only on the occupancy of the selected queue, never on
  // consumer readiness, so a pop cannot open space in the same cycle.
  always_comb begin
    w_full[0] = (r_lvl[0] == FULL_LVL);
    w_full[1] = (r_lvl[1] == FULL_LVL);
    if (select) begin
      in_ready = !w_full[1];
    end else begin
      in_ready = !w_full[0];
    end
    w_acc = in_valid & in_ready;
  end

  // Next-state of each queue: push/pop strobes, read pointer, level, and
  // the word that will sit at the head after this edge.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      w_push[q] = w_acc & (select == 1'(q));
      w_pop[q]  = r_vld[q] & w_ordy[q];
      if (w_pop[q]) begin
        w_rd_nxt[q] = r_rd[q] + PTR_ONE;
      end else begin
        w_rd_nxt[q] = r_rd[q];
      end
      case ({w_push[q], w_pop[q]})
        2'b10:   w_lvl_nxt[q] = r_lvl[q] + LVL_ONE;
        2'b01:   w_lvl_nxt[q] = r_lvl[q] - LVL_ONE;
        default: w_lvl_nxt[q] = r_lvl[q];
      endcase
      // The new head is the incoming word when it lands in the slot the
      // read pointer moves to (queue empty, or level 1 with push+pop).
      if (w_push[q] && (w_rd_nxt[q] == r_wr[q])) begin
        w_head_nxt[q] = in_data;
      end else begin
        w_head_nxt[q] = r_mem[q][w_rd_nxt[q]];
      end
    end
  end

  // Word storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    for (int q = 0; q < 2; q++) begin
      if (w_push[q]) begin
        r_mem[q][r_wr[q]] <= in_data;
      end
    end
  end

  // Pointers, levels, registered head/valid and delivery counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < 2; q++) begin
        r_rd[q]  <= '0;
        r_wr[q]  <= '0;
        r_lvl[q] <= '0;
        r_out[q] <= '0;
        r_vld[q] <= 1'b0;
        r_cnt[q] <= 16'h0000;
      end
    end else begin
      for (int q = 0; q < 2; q++) begin
        if (w_push[q]) begin
          r_wr[q] <= r_wr[q] + PTR_ONE;
        end
        r_rd[q]  <= w_rd_nxt[q];
        r_lvl[q] <= w_lvl_nxt[q];
        r_vld[q] <= (w_lvl_nxt[q] != '0);
        // Output holds its last word while the queue is empty.
        if (w_lvl_nxt[q] != '0) begin
          r_out[q] <= w_head_nxt[q];
        end
        if (w_pop[q]) begin
          r_cnt[q] <= r_cnt[q] + 16'd1;
        end
      end
    end
  end

  assign output0    = r_out[0];
  assign output1    = r_out[1];
  assign out_valid0 = r_vld[0];
  assign out_valid1 = r_vld[1];
  assign level0     = r_lvl[0];
  assign level1     = r_lvl[1];
  assign count0     = r_cnt[0];
  assign count1     = r_cnt[1];

endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: a table of directed vectors from reset, a few
// hand-written corner sequences, and random traffic checked against a
// queue-based reference model.
module tb_demux_router;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        select;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] output0, output1;
  logic        out_valid0, out_valid1;
  logic        out_ready0, out_ready1;
  logic [1:0]  level0, level1;
  logic [15:0] count0, count1;

  demux_router #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .select(select),
    .in_valid(in_valid), .in_ready(in_ready),
    .output0(output0), .output1(output1),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_ready0(out_ready0), .out_ready1(out_ready1),
    .level0(level0), .level1(level1), .count0(count0), .count1(count1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one word queue per output plus counters and last head.
  logic [15:0] mq0[$];
  logic [15:0] mq1[$];
  logic [15:0] mc0, mc1, ml0, ml1;

  typedef struct {
    logic v; logic sel; logic [15:0] d; logic r0; logic r1;
    logic e_rdy;
    logic e_v0; logic [15:0] e_o0; logic [1:0] e_l0; logic [15:0] e_c0;
    logic e_v1; logic [15:0] e_o1; logic [1:0] e_l1; logic [15:0] e_c1;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    mq0.delete(); mq1.delete();
    mc0 = 16'h0; mc1 = 16'h0; ml0 = 16'h0; ml1 = 16'h0;
  endtask

  task automatic model_check();
    chk("out_valid0", 32'(out_valid0), 32'(mq0.size() != 0));
    chk("out_valid1", 32'(out_valid1), 32'(mq1.size() != 0));
    chk("level0", 32'(level0), 32'(mq0.size()));
    chk("level1", 32'(level1), 32'(mq1.size()));
    chk("output0", 32'(output0), 32'(ml0));
    chk("output1", 32'(output1), 32'(ml1));
    chk("count0", 32'(count0), 32'(mc0));
    chk("count1", 32'(count1), 32'(mc1));
  endtask

  // One clock cycle, starting and ending at a falling edge.
  task automatic step(input logic v, input logic sel, input logic [15:0] d,
                      input logic r0, input logic r1, output logic rdy_seen);
    logic exp_rdy, acc, p0, p1;
    in_valid = v; select = sel; in_data = d; out_ready0 = r0; out_ready1 = r1;
    #1;
    rdy_seen = in_ready;
    exp_rdy = sel ? (mq1.size() < DEPTH) : (mq0.size() < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    p0 = r0 && (mq0.size() > 0);
    p1 = r1 && (mq1.size() > 0);
    @(posedge clk);
    if (p0) begin void'(mq0.pop_front()); mc0 = mc0 + 16'd1; end
    if (p1) begin void'(mq1.pop_front()); mc1 = mc1 + 16'd1; end
    if (acc) begin
      if (sel) mq1.push_back(d);
      else     mq0.push_back(d);
    end
    if (mq0.size() > 0) ml0 = mq0[0];
    if (mq1.size() > 0) ml1 = mq1[0];
    @(negedge clk);
    model_check();
  endtask

  // Assert reset at a falling edge, check it takes effect at once and that
  // an offered word is not taken while held, then release.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid0", 32'(out_valid0), 32'd0);
    chk("rst_valid1", 32'(out_valid1), 32'd0);
    chk("rst_level0", 32'(level0), 32'd0);
    chk("rst_level1", 32'(level1), 32'd0);
    chk("rst_output0", 32'(output0), 32'd0);
    chk("rst_output1", 32'(output1), 32'd0);
    chk("rst_count0", 32'(count0), 32'd0);
    chk("rst_count1", 32'(count1), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; select = 1'b0; in_data = 16'hFFFF;
    out_ready0 = 1'b1; out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_noaccept_level0", 32'(level0), 32'd0);
    chk("rst_noaccept_valid0", 32'(out_valid0), 32'd0);
    model_clear();
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic rdy;
    logic [15:0] held;
    rst_n = 1'b0; in_valid = 1'b0; select = 1'b0; in_data = 16'h0;
    out_ready0 = 1'b0; out_ready1 = 1'b0;
    model_clear();

    //         v  s  d        r0 r1 rdy v0 o0       l0 c0      v1 o1       l1 c1
    tbl[0]  = '{1, 0, 16'h1234, 1, 0, 1, 1, 16'h1234, 1, 16'd0, 0, 16'h0000, 0, 16'd0};
    tbl[1]  = '{0, 0, 16'h0000, 1, 0, 1, 0, 16'h1234, 0, 16'd1, 0, 16'h0000, 0, 16'd0};
    tbl[2]  = '{1, 1, 16'hA001, 0, 0, 1, 0, 16'h1234, 0, 16'd1, 1, 16'hA001, 1, 16'd0};
    tbl[3]  = '{1, 1, 16'hA002, 0, 0, 1, 0, 16'h1234, 0, 16'd1, 1, 16'hA001, 2, 16'd0};
    tbl[4]  = '{1, 1, 16'hBEEF, 0, 0, 0, 0, 16'h1234, 0, 16'd1, 1, 16'hA001, 2, 16'd0};
    tbl[5]  = '{0, 0, 16'h0000, 0, 1, 1, 0, 16'h1234, 0, 16'd1, 1, 16'hA002, 1, 16'd1};
    tbl[6]  = '{0, 1, 16'h0000, 0, 1, 1, 0, 16'h1234, 0, 16'd1, 0, 16'hA002, 0, 16'd2};
    tbl[7]  = '{1, 0, 16'h0001, 1, 1, 1, 1, 16'h0001, 1, 16'd1, 0, 16'hA002, 0, 16'd2};
    tbl[8]  = '{1, 1, 16'h0002, 1, 1, 1, 0, 16'h0001, 0, 16'd2, 1, 16'h0002, 1, 16'd2};
    tbl[9]  = '{1, 0, 16'h0003, 1, 1, 1, 1, 16'h0003, 1, 16'd2, 0, 16'h0002, 0, 16'd3};
    tbl[10] = '{1, 1, 16'h0004, 1, 1, 1, 0, 16'h0003, 0, 16'd3, 1, 16'h0004, 1, 16'd3};
    tbl[11] = '{0, 0, 16'h0000, 1, 1, 1, 0, 16'h0003, 0, 16'd3, 0, 16'h0004, 0, 16'd4};
    tbl[12] = '{1, 0, 16'h00AA, 0, 0, 1, 1, 16'h00AA, 1, 16'd3, 0, 16'h0004, 0, 16'd4};
    tbl[13] = '{1, 0, 16'h00BB, 1, 0, 1, 1, 16'h00BB, 1, 16'd4, 0, 16'h0004, 0, 16'd4};
    tbl[14] = '{0, 0, 16'h0000, 1, 0, 1, 0, 16'h00BB, 0, 16'd5, 0, 16'h0004, 0, 16'd4};

    // Power-up reset state and no accept while reset is held.
    @(negedge clk);
    do_reset();

    // Directed table from reset.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1, rdy);
      chk($sformatf("t%0d_in_ready", i), 32'(rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("t%0d_valid0", i), 32'(out_valid0), 32'(tbl[i].e_v0));
      chk($sformatf("t%0d_output0", i), 32'(output0), 32'(tbl[i].e_o0));
      chk($sformatf("t%0d_level0", i), 32'(level0), 32'(tbl[i].e_l0));
      chk($sformatf("t%0d_count0", i), 32'(count0), 32'(tbl[i].e_c0));
      chk($sformatf("t%0d_valid1", i), 32'(out_valid1), 32'(tbl[i].e_v1));
      chk($sformatf("t%0d_output1", i), 32'(output1), 32'(tbl[i].e_o1));
      chk($sformatf("t%0d_level1", i), 32'(level1), 32'(tbl[i].e_l1));
      chk($sformatf("t%0d_count1", i), 32'(count1), 32'(tbl[i].e_c1));
    end

    // Full queue with a pop in the same cycle: no push until next cycle.
    step(1'b1, 1'b0, 16'h0C01, 1'b0, 1'b0, rdy);
    step(1'b1, 1'b0, 16'h0C02, 1'b0, 1'b0, rdy);
    step(1'b1, 1'b0, 16'h0C03, 1'b1, 1'b0, rdy);
    chk("full_pop_in_ready", 32'(rdy), 32'd0);
    chk("full_pop_level0", 32'(level0), 32'd1);
    chk("full_pop_head", 32'(output0), 32'h0C02);
    step(1'b1, 1'b0, 16'h0C04, 1'b0, 1'b0, rdy);
    chk("after_full_in_ready", 32'(rdy), 32'd1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, rdy);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, rdy);

    // Stalled output0 stays stable while traffic flows to output1.
    step(1'b1, 1'b0, 16'h5A5A, 1'b0, 1'b0, rdy);
    held = 16'h5A5A;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 16'($urandom), 1'b0, 1'($urandom), rdy);
      chk("stall_output0", 32'(output0), 32'(held));
      chk("stall_valid0", 32'(out_valid0), 32'd1);
    end
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, rdy);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, rdy);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, rdy);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom), 1'($urandom), 16'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), rdy);
    end

    // Counter wrap: 65537 pops from reset leaves count0 at 1.
    do_reset();
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, rdy);
    for (int i = 1; i <= 65536; i++) begin
      step(1'b1, 1'b0, 16'(i), 1'b1, 1'b0, rdy);
    end
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, rdy);
    chk("wrap_count0", 32'(count0), 32'h0001);

    // Reset mid-operation with queue 0 full, then a fresh first accept.
    step(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, rdy);
    step(1'b1, 1'b0, 16'h2222, 1'b0, 1'b0, rdy);
    chk("pre_reset_level0", 32'(level0), 32'd2);
    do_reset();
    step(1'b1, 1'b0, 16'h7777, 1'b0, 1'b0, rdy);
    chk("post_reset_output0", 32'(output0), 32'h7777);
    chk("post_reset_level0", 32'(level0), 32'd1);

    for (int i = 0; i < 500; i++) begin
      step(1'($urandom), 1'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
